// File: rtl/display_pkg.sv
// Shared types and widths for the seven-segment display sharing logic.
package display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int DISP_W     = 16;
  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_rr_picker.sv
// Round-robin search: first set req bit at or above ptr, wrapping around.
module display_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/display_share_arbiter.sv
// Round-robin owner of the 4-digit display; holds each granted value for HOLD_CYCLES.
// Optional blank gap between grants when DISP_ARB_BLANK_EN is defined.
module display_share_arbiter
  import display_pkg::*;
#(
  parameter int              NUM_REQ      = 4,
  parameter int              HOLD_CYCLES  = 100000000,
  parameter int              BLANK_CYCLES = 10000000,
  parameter logic [DISP_W-1:0] IDLE_VALUE = 16'h0000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [DISP_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic [DIGIT_W-1:0]        hex3,
  output logic [DIGIT_W-1:0]        hex2,
  output logic [DIGIT_W-1:0]        hex1,
  output logic [DIGIT_W-1:0]        hex0,
  output logic                      busy,
  output logic                      blank
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, BLANK_CYCLES) + 1);

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [PTR_W-1:0]    ptr_reg;
  logic [NUM_REQ-1:0]  grant_reg, ack_reg;
  logic [DISP_W-1:0]   hex_reg;
  logic                busy_reg;
  logic                found;
  logic [PTR_W-1:0]    winner, ptr_next;
  logic [NUM_REQ-1:0]  win_onehot;
  logic                cnt_zero;
  logic                do_grant, go_idle;
  logic [DISP_W-1:0]   data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[DISP_W*gi +: DISP_W];
    end
  endgenerate

  display_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_reg),
    .found  (found),
    .winner (winner)
  );

  assign cnt_zero = (cnt_reg == '0);
  assign ptr_next = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

`ifdef DISP_ARB_BLANK_EN
  logic go_gap;
  logic blank_reg;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Requests are only looked at in IDLE and on the last cycle of SHOW/GAP.
  always_comb begin
    do_grant = 1'b0;
    go_idle  = 1'b0;
`ifdef DISP_ARB_BLANK_EN
    go_gap   = 1'b0;
`endif
    case (state_reg)
      IDLE: if (found) do_grant = 1'b1;
      SHOW: if (cnt_zero) begin
`ifdef DISP_ARB_BLANK_EN
        go_gap = 1'b1;
`else
        if (found) do_grant = 1'b1;
        else       go_idle  = 1'b1;
`endif
      end
`ifdef DISP_ARB_BLANK_EN
      GAP: if (cnt_zero) begin
        if (found) do_grant = 1'b1;
        else       go_idle  = 1'b1;
      end
`endif
      default: go_idle = 1'b1;
    endcase

    state_next = state_reg;
    if (do_grant)     state_next = SHOW;
`ifdef DISP_ARB_BLANK_EN
    else if (go_gap)  state_next = GAP;
`endif
    else if (go_idle) state_next = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hex_reg   <= IDLE_VALUE;
      grant_reg <= '0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
`ifdef DISP_ARB_BLANK_EN
      blank_reg <= 1'b0;
`endif
    end else begin
      ack_reg  <= '0;
      busy_reg <= (state_next != IDLE);
`ifdef DISP_ARB_BLANK_EN
      blank_reg <= (state_next == GAP);
`endif
      if (do_grant) begin
        hex_reg   <= data_arr[winner];
        grant_reg <= win_onehot;
        ack_reg   <= win_onehot;
        cnt_reg   <= CNT_W'(HOLD_CYCLES - 1);
        ptr_reg   <= ptr_next;
      end
`ifdef DISP_ARB_BLANK_EN
      else if (go_gap) begin
        grant_reg <= '0;
        cnt_reg   <= CNT_W'(BLANK_CYCLES - 1);
      end
`endif
      else if (go_idle) begin
        grant_reg <= '0;
      end else if (!cnt_zero) begin
        cnt_reg <= cnt_reg - 1'b1;
      end
    end
  end

  assign ack   = ack_reg;
  assign grant = grant_reg;
  assign busy  = busy_reg;
  assign hex3  = hex_reg[15:12];
  assign hex2  = hex_reg[11:8];
  assign hex1  = hex_reg[7:4];
  assign hex0  = hex_reg[3:0];
`ifdef DISP_ARB_BLANK_EN
  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter: table vectors, directed corners, random vs model.
module tb_display_share_arbiter;

  localparam int N     = 4;
  localparam int HOLD  = 4;
  localparam int BLANK = 2;
`ifdef DISP_ARB_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam int PERIOD = HOLD + (BLANK_EN ? BLANK : 0);

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [16*N-1:0] req_data;
  logic [N-1:0]  ack, grant;
  logic [3:0]    hex3, hex2, hex1, hex0;
  logic          busy, blank;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  display_share_arbiter #(
    .NUM_REQ      (N),
    .HOLD_CYCLES  (HOLD),
    .BLANK_CYCLES (BLANK),
    .IDLE_VALUE   (16'h0000)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .grant    (grant),
    .hex3     (hex3),
    .hex2     (hex2),
    .hex1     (hex1),
    .hex0     (hex0),
    .busy     (busy),
    .blank    (blank)
  );

  // Reference model: absolute cycle of next decision instead of a down-counter.
  int          cyc;
  int          m_mode;   // 0 idle, 1 showing, 2 blank gap
  int          m_dec;
  int          m_ptr;
  logic [N-1:0] m_grant, m_ack;
  logic [15:0] m_hex;
  logic        m_blank;

  function automatic logic [25:0] outs();
    return {grant, ack, hex3, hex2, hex1, hex0, busy, blank};
  endfunction

  function automatic logic [25:0] model_outs();
    return {m_grant, m_ack, m_hex, (m_mode != 0), m_blank};
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_dec   = 0;
    m_ptr   = 0;
    m_grant = '0;
    m_ack   = '0;
    m_hex   = 16'h0000;
    m_blank = 1'b0;
  endtask

  task automatic model_step();
    int w;
    m_ack = '0;
    if (m_mode == 0 || cyc == m_dec) begin
      if (m_mode == 1 && BLANK_EN) begin
        m_mode  = 2;
        m_grant = '0;
        m_blank = 1'b1;
        m_dec   = cyc + BLANK;
      end else begin
        m_blank = 1'b0;
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (w >= 0) begin
          m_grant    = '0;
          m_grant[w] = 1'b1;
          m_ack      = m_grant;
          m_hex      = req_data[16*w +: 16];
          m_ptr      = (w + 1) % N;
          m_mode     = 1;
          m_dec      = cyc + HOLD;
        end else begin
          m_mode  = 0;
          m_grant = '0;
        end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    cyc++;
    check("model", outs(), model_outs());
    if (ack != '0)
      $display("txn t=%0t ack=%b grant=%b hex=%h%h%h%h", $time, ack, grant, hex3, hex2, hex1, hex0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_async", outs(), 26'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [15:0]  hex;
    logic         busy;
    logic         blank;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [15:0] saved;
    logic [N-1:0] seq [$];
    int           when [$];
    int           acks;
    int           budget;

    tbl[0] = '{4'b0100, 4'b0100, 4'b0100, 16'hBEEF, 1'b1, 1'b0};
    for (int i = 1; i < 4; i++) tbl[i] = '{4'b0000, 4'b0100, 4'b0000, 16'hBEEF, 1'b1, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 16'hBEEF, BLANK_EN, BLANK_EN};
    tbl[5] = '{4'b0000, 4'b0000, 4'b0000, 16'hBEEF, BLANK_EN, BLANK_EN};
    tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 16'hBEEF, 1'b0, 1'b0};

    cyc      = 0;
    req      = '0;
    req_data = {16'h4444, 16'hBEEF, 16'h2222, 16'h1111};
    model_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_state", outs(), 26'h0);
    reset = 1'b0;

    // Single request, dropped on ack: 4-cycle dwell then idle with value kept
    for (int i = 0; i < 7; i++) begin
      req = tbl[i].req;
      step();
      check($sformatf("table%0d", i), outs(),
            {tbl[i].grant, tbl[i].ack, tbl[i].hex, tbl[i].busy, tbl[i].blank});
    end

    // Reset while requester 1 is on display
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b0000;
    step();
    check("pre_reset_grant", {22'h0, grant}, 26'h2);
    do_reset();

    // Round-robin order with req=1011 held
    req = 4'b1011;
    budget = 0;
    while (seq.size() < 4 && budget < 60) begin
      step();
      budget++;
      if (ack != '0) begin
        seq.push_back(ack);
        when.push_back(cyc);
      end
    end
    if (seq.size() < 4) check("rr_budget", 26'(seq.size()), 26'd4);
    else begin
      check("rr_seq", {10'h0, seq[0], seq[1], seq[2], seq[3]}, {10'h0, 4'b0001, 4'b0010, 4'b1000, 4'b0001});
      for (int i = 1; i < 4; i++) check("rr_spacing", 26'(when[i] - when[i-1]), 26'(PERIOD));
    end
    req = '0;
    for (int i = 0; i < 2 * PERIOD; i++) step();

    // Data of the displayed requester changes during its dwell
    req = 4'b0001;
    step();
    saved = {hex3, hex2, hex1, hex0};
    req = 4'b0000;
    req_data[15:0] = 16'h9999;
    step();
    step();
    check("data_hold", {10'h0, hex3, hex2, hex1, hex0}, {10'h0, saved});
    for (int i = 0; i < 2 * PERIOD; i++) step();

    // Only requester 3 held: re-granted each period, busy stays high
    do_reset();
    req  = 4'b1000;
    acks = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (ack == 4'b1000) acks++;
      check("busy_held", {25'h0, busy}, 26'h1);
    end
    check("wrap_acks", 26'(acks), 26'(1 + 12 / PERIOD));
    req = '0;
    for (int i = 0; i < 2 * PERIOD; i++) step();

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req_data = {$urandom, $urandom};
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
